// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message sequencer.
//   - UART command codes understood by sha256_seq
//   - SHA-256 initial hash value (chaining value for the first chunk)
//   - sequencer FSM state encoding
package sha256_pkg;

  localparam logic [7:0] CMD_NONE        = 8'h00;
  localparam logic [7:0] CMD_HASH        = 8'h01;
  localparam logic [7:0] CMD_SEND_DIGEST = 8'h02;
  localparam logic [7:0] CMD_SEND_HI     = 8'h03;
  localparam logic [7:0] CMD_SEND_LO     = 8'h04;
  localparam logic [7:0] CMD_INIT        = 8'h05;

  localparam logic [255:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HSTART = 3'd1,
    ST_HWAIT  = 3'd2,
    ST_TSTART = 3'd3,
    ST_TWAIT  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/sha256_rise.sv
// One-register rising-edge detector.
//   Clk   : system clock
//   Reset : asynchronous active-low reset
//   level : level to watch (sampled every cycle)
//   rise  : high while level is high and was low at the previous edge
module sha256_rise (
  input  logic Clk,
  input  logic Reset,
  input  logic level,
  output logic rise
);

  logic level_last;

  // NOTE: state registers are written with <= only; blocking here would let
  // downstream flops in the same block see this cycle's value too early.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) level_last <= 1'b0;
    else        level_last <= level;
  end

  // A level that is already high when the watcher starts caring never counts.
  assign rise = level & ~level_last;

endmodule

// File: rtl/sha256_seq.sv
// Multi-chunk SHA-256 message sequencer.
// Decodes single-byte UART commands, starts the hash core once per chunk,
// keeps the chaining value between chunks and schedules UART readback of
// the digest or of either half of the current chunk.
//   Clk, Reset        : clock, asynchronous active-low reset
//   Command           : command byte from uart_rx (level, held)
//   chunk             : current 512-bit chunk from uart_rx
//   digest            : core result
//   DigestReady       : core done level
//   DigestTransmitted : tx done level
//   hash_start        : one-cycle core start pulse
//   hash_in           : chaining value fed to the core
//   transmit_start    : one-cycle tx start pulse
//   send              : tx payload, stable for the whole transmission
//   busy              : FSM not idle
//   error             : sticky, dropped command or core timeout
//   chunk_count       : chunks absorbed since the last INIT
module sha256_seq
  import sha256_pkg::*;
#(
  parameter int TIMEOUT   = 1024,
  parameter bit AUTO_SEND = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [7:0]       Command,
  input  logic [511:0]     chunk,
  input  logic [255:0]     digest,
  input  logic             DigestReady,
  input  logic             DigestTransmitted,
  output logic             hash_start,
  output logic [255:0]     hash_in,
  output logic             transmit_start,
  output logic [255:0]     send,
  output logic             busy,
  output logic             error,
  output logic [CNT_W-1:0] chunk_count
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  seq_state_e       state, state_nxt;
  logic [7:0]       cmd_last;
  logic [255:0]     chain;
  logic [TMR_W-1:0] timer;
  logic             new_cmd;
  logic             dr_rise, dt_rise;
  logic             hash_done, hash_timeout;

  sha256_rise u_rise_ready (
    .Clk   (Clk),
    .Reset (Reset),
    .level (DigestReady),
    .rise  (dr_rise)
  );

  sha256_rise u_rise_tx (
    .Clk   (Clk),
    .Reset (Reset),
    .level (DigestTransmitted),
    .rise  (dt_rise)
  );

  // A command is new only when the byte changes to a non-zero value, so a
  // repeated code has to pass through another value (normally 0x00).
  assign new_cmd = (Command != cmd_last) && (Command != CMD_NONE);

  // The done edge beats a timeout landing in the same cycle.
  assign hash_done    = (state == ST_HWAIT) && dr_rise;
  assign hash_timeout = (state == ST_HWAIT) && !dr_rise &&
                        (timer == TMR_W'(TIMEOUT - 1));

  assign hash_start     = (state == ST_HSTART);
  assign transmit_start = (state == ST_TSTART);
  assign busy           = (state != ST_IDLE);
  assign hash_in        = chain;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch forms.
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (new_cmd) begin
          case (Command)
            CMD_HASH:                              state_nxt = ST_HSTART;
            CMD_SEND_DIGEST, CMD_SEND_HI, CMD_SEND_LO: state_nxt = ST_TSTART;
            default:                               state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_HSTART: state_nxt = ST_HWAIT;
      ST_HWAIT: begin
        if (hash_done)         state_nxt = AUTO_SEND ? ST_TSTART : ST_IDLE;
        else if (hash_timeout) state_nxt = ST_IDLE;
      end
      ST_TSTART: state_nxt = ST_TWAIT;
      ST_TWAIT:  if (dt_rise) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Datapath. Later assignments in this block take priority, which encodes
  // the overlap rules: a chunk capture overwrites an INIT issued during the
  // same hash, and a timeout sets error after any INIT clear.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cmd_last    <= CMD_NONE;
      chain       <= SHA256_IV;
      chunk_count <= '0;
      send        <= '0;
      error       <= 1'b0;
      timer       <= '0;
    end else begin
      cmd_last <= Command;

      if (state == ST_HSTART)     timer <= '0;
      else if (state == ST_HWAIT) timer <= timer + TMR_W'(1);

      if (new_cmd) begin
        if (Command == CMD_INIT) begin
          chain       <= SHA256_IV;
          chunk_count <= '0;
          error       <= 1'b0;
        end else if (state == ST_IDLE) begin
          case (Command)
            CMD_SEND_DIGEST: send <= chain;
            CMD_SEND_HI:     send <= chunk[511:256];
            CMD_SEND_LO:     send <= chunk[255:0];
            default:         ;
          endcase
        end else begin
          error <= 1'b1;
        end
      end

      if (hash_done) begin
        chain       <= digest;
        chunk_count <= chunk_count + CNT_W'(1);
        if (AUTO_SEND) send <= digest;
      end

      if (hash_timeout) error <= 1'b1;
    end
  end

endmodule

// File: doc/sha256_seq.md
# sha256_seq

Multi-chunk message sequencer for the SHA-256 core. It turns single-byte UART commands into a controlled run of core invocations, holds the chaining value between 512-bit chunks, and schedules digest and chunk readback through the UART transmitter. It sits between `uart_rx` (Command/chunk source), `sha256` (hash core), and `uart_tx` (send path). It is the control unit for messages longer than one chunk.

## Interface
- `TIMEOUT`, 1024: max cycles in HASH_WAIT before abort.
- `AUTO_SEND`, 1: 1 = transmit the digest automatically after each completed chunk.
- `CNT_W`, 16: width of chunk counter.

- `Clk`  in  1  system clock, single clock domain.
- `Reset`  in  1  asynchronous, active-low reset.
- `Command`  in  8  level from `uart_rx`, held until the next command.
- `chunk`  in  512  current chunk from `uart_rx`.
- `digest`  in  256  core output.
- `DigestReady`  in  1  core done level.
- `DigestTransmitted`  in  1  tx done level.
- `hash_start`  out  1  one-cycle start pulse to core.
- `hash_in`  out  256  chaining value fed to core.
- `transmit_start`  out  1  one-cycle start pulse to tx.
- `send`  out  256  tx payload, stable from start until TX_WAIT exit.
- `busy`  out  1  FSM not in IDLE.
- `error`  out  1  sticky: dropped command or timeout.
- `chunk_count`  out  CNT_W  chunks absorbed since last chain reset.

## Operation
- Command codes:
  - 0x01 HASH: absorb chunk.
  - 0x02 SEND digest: send = chain.
  - 0x03 SEND chunk[511:256].
  - 0x04 SEND chunk[255:0].
  - 0x05 INIT: chain <= IV, chunk_count <= 0, error <= 0.
  - Other codes: ignored, no error.
- New command detect: `Command != cmd_last && Command != 0`. `cmd_last` is updated every cycle. Repeating one code requires rx to change value (e.g. through 0x00) in between.
- FSM states: IDLE, HSTART, HWAIT, TSTART, TWAIT.
  - IDLE + HASH -> HSTART.
  - IDLE + SEND* -> TSTART, with send latched at detection.
  - IDLE + INIT: acted on immediately, FSM stays in IDLE.
  - HSTART -> HWAIT, unconditional.
  - HWAIT + DigestReady rising edge: chain <= digest, chunk_count++ (wraps). Then -> TSTART if AUTO_SEND (send <= digest), else -> IDLE.
  - HWAIT + timer == TIMEOUT-1: error <= 1, chain unchanged, -> IDLE.
  - TSTART -> TWAIT.
  - TWAIT + DigestTransmitted rising edge -> IDLE.
- `hash_in` = chain register at all times.
- New command while busy:
  - INIT: applied; chain update at HWAIT exit still overwrites it.
  - Any other code: dropped, error <= 1.
- DigestReady rising edge and timeout in the same cycle: the edge wins, no error.
- Rise detectors sample DigestReady/DigestTransmitted every cycle, so a level already high on entry does not count as an edge.

## Timing
- Reset values:
  - hash_start, transmit_start, busy, error = 0.
  - send = 0, chunk_count = 0.
  - hash_in = IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19).
  - FSM = IDLE, cmd_last = 0.
- Command visible at edge N:
  - Detection at edge N; FSM in HSTART/TSTART after edge N.
  - hash_start/transmit_start high for exactly the cycle after edge N.
- Digest capture: the edge after DigestReady is first sampled high (after `DigestReady_last` low). With AUTO_SEND, transmit_start pulses one cycle later.
- Timer: cleared on HWAIT entry, increments each HWAIT cycle.
- Reset mid-operation: all state returns to reset values immediately. Core and tx are reset by the same `Reset`.

## Structure
- Package `sha256_pkg`: command code constants, IV constant, FSM state encoding.
- Sub-module `sha256_rise`: one-register rising-edge detector. Instantiated twice, for DigestReady and DigestTransmitted.
- The parent control unit replaces its ad-hoc always block with this block; `uart_rx`, `uart_tx`, and `sha256` are unchanged apart from the core taking `hash_in`.

## Test plan
- Reset -> hash_in = IV, all pulses 0, chunk_count = 0, busy = 0.
- Padded "abc" chunk, Command 0x01 -> one hash_start pulse. Core model raises DigestReady 68 cycles later. Then chain = ba7816bf…f20015ad, chunk_count = 1, transmit_start pulse, send = digest.
- Two-chunk message (56×"a" style padding across 2 chunks), 0x01, 0x00, 0x01 -> second hash_in equals first digest; final digest matches reference model; chunk_count = 2.
- Command 0x03 while in HWAIT -> dropped, error = 1, hash completes normally; then 0x05 -> error = 0, chain = IV.
- DigestReady held low, TIMEOUT = 16 -> error = 1 after 16 HWAIT cycles, chain unchanged, back to IDLE.
- Reset asserted in TWAIT -> all outputs reset values; after release, 0x02 -> send = IV, one transmit_start pulse.
